// File: rtl/cic_decim_integ.sv
// Cascaded integrator and runtime-rate downsampler for the I/Q CIC decimator front half.
// Build option: define CIC_DECIM_INTEG_CLEAR_EN to add the synchronous i_clear port.
module cic_decim_integ #(
  parameter int IN_WIDTH   = 16,
  parameter int WIDTH      = 32,
  parameter int STAGES     = 3,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
`ifdef CIC_DECIM_INTEG_CLEAR_EN
  input  logic                  i_clear,
`endif
  input  logic [RATE_WIDTH-1:0] i_rate,
  input  logic [IN_WIDTH-1:0]   i_inph_data,
  input  logic [IN_WIDTH-1:0]   i_quad_data,
  input  logic                  i_valid,
  output logic [WIDTH-1:0]      o_inph_data,
  output logic [WIDTH-1:0]      o_quad_data,
  output logic                  o_valid
);

  // Reset asserts asynchronously everywhere; release reaches the datapath two edges later.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [WIDTH-1:0]      w_x_i;
  logic [WIDTH-1:0]      w_x_q;
  logic [WIDTH-1:0]      r_acc_i [STAGES];
  logic [WIDTH-1:0]      r_acc_q [STAGES];
  logic [WIDTH-1:0]      w_nxt_i [STAGES];
  logic [WIDTH-1:0]      w_nxt_q [STAGES];
  logic [RATE_WIDTH-1:0] r_cnt;
  logic [RATE_WIDTH-1:0] r_rate_q;
  logic [RATE_WIDTH-1:0] w_eff_rate;
  logic                  w_terminal;
  logic [WIDTH-1:0]      r_out_i;
  logic [WIDTH-1:0]      r_out_q;
  logic                  r_valid;

  assign w_x_i = WIDTH'(signed'(i_inph_data));
  assign w_x_q = WIDTH'(signed'(i_quad_data));

  // Every stage sums against the pre-update value of the stage before it.
  always_comb begin
    w_nxt_i[0] = r_acc_i[0] + w_x_i;
    w_nxt_q[0] = r_acc_q[0] + w_x_q;
    for (int k = 1; k < STAGES; k++) begin
      w_nxt_i[k] = r_acc_i[k] + r_acc_i[k-1];
      w_nxt_q[k] = r_acc_q[k] + r_acc_q[k-1];
    end
  end

  assign w_eff_rate = (i_rate < RATE_WIDTH'(2)) ? RATE_WIDTH'(1) : i_rate;
  assign w_terminal = (r_cnt == '0) ? (w_eff_rate == RATE_WIDTH'(1))
                                    : (r_cnt == r_rate_q - RATE_WIDTH'(1));

  // o_valid is a one-cycle strobe with no backpressure: each terminal i_valid
  // produces exactly one strobe on the following edge, with data stable until the next one.
  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_acc_i[k] <= '0;
        r_acc_q[k] <= '0;
      end
      r_cnt    <= '0;
      r_rate_q <= RATE_WIDTH'(1);
      r_out_i  <= '0;
      r_out_q  <= '0;
      r_valid  <= 1'b0;
    end
`ifdef CIC_DECIM_INTEG_CLEAR_EN
    else if (i_clear) begin
      for (int k = 0; k < STAGES; k++) begin
        r_acc_i[k] <= '0;
        r_acc_q[k] <= '0;
      end
      r_cnt    <= '0;
      r_rate_q <= RATE_WIDTH'(1);
      r_valid  <= 1'b0;
    end
`endif
    else begin
      r_valid <= 1'b0;
      if (i_valid) begin
        r_acc_i <= w_nxt_i;
        r_acc_q <= w_nxt_q;
        if (r_cnt == '0) r_rate_q <= w_eff_rate;
        if (w_terminal) begin
          r_cnt   <= '0;
          r_out_i <= w_nxt_i[STAGES-1];
          r_out_q <= w_nxt_q[STAGES-1];
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + RATE_WIDTH'(1);
        end
      end
    end
  end

  assign o_inph_data = r_out_i;
  assign o_quad_data = r_out_q;
  assign o_valid     = r_valid;

endmodule
